// File: rtl/rr_arbiter_16_if.sv
// rr_arbiter_16_if: request/grant bundle between requesting agents and the arbiter
interface rr_arbiter_16_if;
    logic        enable;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    modport master(output enable, req, input grant, grant_idx, grant_valid);
    modport slave(input enable, req, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way registered round-robin arbiter with hold limit under contention
module rr_arbiter_16 #(
    parameter int HOLD_MAX = 8
) (
    input logic         clk,
    input logic         reset,
    rr_arbiter_16_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]  state;
    logic [15:0] g;
    logic [3:0]  idx;
    logic        vld;
    logic [3:0]  last;
    logic [7:0]  hold_cnt;
    logic [15:0] others;
    logic        move;
    logic [4:0]  nxt;

    // First set bit scanning l+1 .. l+16 (wrapping), returned as {found, index}
    function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] l);
        logic [4:0] p;
        logic [3:0] i;
        p = '0;
        for (int k = 16; k >= 1; k--) begin
            i = l + 4'(k);
            if (r[i]) p = {1'b1, i};
        end
        return p;
    endfunction

    always_comb begin
        others = bus.req & ~g;
        move = !(|(bus.req & g)) || (hold_cnt == 8'(HOLD_MAX - 1) && |others);
        nxt = (state == IDLE) ? pick(bus.req, last) : pick(others, last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            g <= '0;
            idx <= '0;
            vld <= 1'b0;
            last <= 4'hF;
            hold_cnt <= '0;
        end else if (!bus.enable) begin
            state <= IDLE;
            g <= '0;
            idx <= '0;
            vld <= 1'b0;
            hold_cnt <= '0;
        end else if (state == IDLE || move) begin
            state <= nxt[4] ? GRANT : IDLE;
            g <= nxt[4] ? 16'(1) << nxt[3:0] : '0;
            idx <= nxt[4] ? nxt[3:0] : '0;
            vld <= nxt[4];
            last <= nxt[4] ? nxt[3:0] : last;
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 8'(hold_cnt != 8'hFF);
        end
    end

    assign bus.grant = g;
    assign bus.grant_idx = idx;
    assign bus.grant_valid = vld;
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: directed plan plus randomized traffic against a behavioural arbiter model
module tb_rr_arbiter_16;
    localparam int H = 4;
    logic clk = 0;
    logic reset = 1;
    rr_arbiter_16_if bus();
    rr_arbiter_16 #(.HOLD_MAX(H)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;
    bit m_valid;
    int m_owner, m_last, m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int search(input logic [15:0] r, input int after, input bit excl);
        for (int k = 1; k <= 16; k++) begin
            int i;
            i = (after + k) % 16;
            if (!(excl && i == after) && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (reset) begin
            m_valid = 0; m_last = 15; m_hold = 0;
        end else if (!bus.enable) begin
            m_valid = 0; m_hold = 0;
        end else if (!m_valid) begin
            w = search(bus.req, m_last, 0);
            if (w >= 0) begin m_valid = 1; m_owner = w; m_last = w; m_hold = 0; end
        end else if (!bus.req[m_owner] ||
                     (m_hold == H - 1 && (bus.req & ~(16'd1 << m_owner)) != 0)) begin
            w = search(bus.req, m_owner, 1);
            if (w < 0) begin m_valid = 0; m_hold = 0; end
            else begin m_owner = w; m_last = w; m_hold = 0; end
        end else begin
            m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".grant"}, 32'(bus.grant), m_valid ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".idx"}, 32'(bus.grant_idx), m_valid ? 32'(m_owner) : 32'd0);
        chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(m_valid));
    endtask

    task automatic do_reset();
        reset = 1;
        step("reset");
        chk("reset.zero", {16'(bus.grant), 4'(bus.grant_idx), 1'(bus.grant_valid)}, 0);
        reset = 0;
    endtask

    initial begin
        bus.enable = 1;
        bus.req = '0;
        do_reset();
        bus.req = 16'h8001; step("t1a"); chk("t1a.k", 32'(bus.grant), 32'h0001);
        bus.req = 16'h8000; step("t1b"); chk("t1b.k", 32'(bus.grant_idx), 15);

        do_reset();
        bus.req = 16'h0003;
        for (int c = 0; c < 12; c++) begin
            step("t2");
            chk("t2.k", 32'(bus.grant_idx), 32'((c / H) % 2));
        end

        do_reset();
        bus.req = 16'h4000;
        for (int c = 0; c < 300; c++) step("t3");
        chk("t3.k", 32'(bus.grant_idx), 14);

        do_reset();
        bus.req = 16'h0004; step("t4a");
        bus.req = 16'h4004; bus.enable = 0; step("t4b"); chk("t4b.k", 32'(bus.grant), 0);
        bus.enable = 1; step("t4c"); chk("t4c.k", 32'(bus.grant_idx), 14);

        do_reset();
        bus.req = 16'h0200; step("t5a");
        reset = 1; step("t5b"); chk("t5b.k", 32'(bus.grant_valid), 0);
        reset = 0; bus.req = 16'h0600; step("t5c"); chk("t5c.k", 32'(bus.grant_idx), 9);

        do_reset();
        bus.req = 16'h0020;
        for (int c = 0; c < H; c++) step("t6a");
        bus.req = 16'h0100; step("t6b"); chk("t6b.k", 32'(bus.grant_idx), 8);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 16'($urandom) & 16'($urandom);
            else if ($urandom_range(0, 4) == 0) bus.req = bus.req & ~bus.grant;
            bus.enable = $urandom_range(0, 19) != 0;
            reset = $urandom_range(0, 199) == 0;
            step("rnd");
        end
        reset = 0;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
